// File: rtl/store_buffer_pkg.sv
// sb_pkg: shared types and helpers for the store buffer.
//   SB_WIDTH / SB_DEPTH : default data/address width and buffer depth
//   SB_PTR_W            : head/tail pointer width
//   sb_entry_t          : one buffered store {addr, data}
//   word_addr()         : word address of a byte address (drops bits [1:0])
package sb_pkg;

    localparam int SB_WIDTH = 32;
    localparam int SB_DEPTH = 4;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [SB_WIDTH-1:0] addr;
        logic [SB_WIDTH-1:0] data;
    } sb_entry_t;

    function automatic logic [SB_WIDTH-3:0] word_addr(input logic [SB_WIDTH-1:0] byteAddr);
        return byteAddr[SB_WIDTH-1:2];
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: RAM write channel of the store buffer (valid/ready).
//   ram_wvalid : write request for the head entry (master -> slave)
//   ram_waddr  : head entry address                (master -> slave)
//   ram_wdata  : head entry data                   (master -> slave)
//   ram_wready : RAM accepts the write             (slave -> master)
interface store_buffer_if #(
    parameter int WIDTH = 32
);
    logic             ram_wvalid;
    logic             ram_wready;
    logic [WIDTH-1:0] ram_waddr;
    logic [WIDTH-1:0] ram_wdata;

    modport master (
        output ram_wvalid,
        output ram_waddr,
        output ram_wdata,
        input  ram_wready
    );

    modport slave (
        input  ram_wvalid,
        input  ram_waddr,
        input  ram_wdata,
        output ram_wready
    );
endinterface

// File: rtl/store_buffer_match.sv
// sb_match: word-address match of a lookup address against all buffered
// stores, plus selection of the youngest matching entry.
//   entries    : buffer storage
//   validMask  : per-slot valid bit
//   head/count : FIFO position, used to walk entries oldest -> youngest
//   lookupAddr : byte address being looked up
//   matchVec   : per-slot match (valid and same word)
//   hit        : at least one slot matches
//   hitIdx     : slot index of the youngest match (head when no hit)
module sb_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  sb_entry_t             entries [DEPTH],
    input  logic [DEPTH-1:0]      validMask,
    input  logic [SB_PTR_W-1:0]   head,
    input  logic [SB_PTR_W:0]     count,
    input  logic [SB_WIDTH-1:0]   lookupAddr,
    output logic [DEPTH-1:0]      matchVec,
    output logic                  hit,
    output logic [SB_PTR_W-1:0]   hitIdx
);

    logic [SB_PTR_W-1:0] slot;

    always_comb begin
        matchVec = '0;
        hit      = 1'b0;
        hitIdx   = head;
        slot     = head;
        for (int i = 0; i < DEPTH; i++) begin
            matchVec[i] = validMask[i] &&
                          (word_addr(entries[i].addr) == word_addr(lookupAddr));
        end
        // Walk from oldest to youngest; the last hit seen is the youngest.
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + SB_PTR_W'(k);
            if (((SB_PTR_W+1)'(k) < count) && matchVec[slot]) begin
                hit    = 1'b1;
                hitIdx = slot;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core M stage and the data RAM.
// Stores are queued and drained over ramWr (valid/ready); loads read the RAM
// combinationally.
// Build option: define STORE_FWD_EN to forward the youngest buffered store to
// a matching load. Without it, a load that hits a buffered store stalls until
// every matching entry has drained.
//   clk, rst (async, active-low)
//   memwriteM, loadM, aluresultM, writedataM : M-stage access
//   readdataM  : load data (combinational)
//   stallM     : hold M and earlier stages (combinational)
//   ram_raddr / ram_rdata : RAM combinational read port
//   ramWr      : RAM write channel (store_buffer_if.master)
//   empty      : no buffered stores
// WIDTH/DEPTH must match SB_WIDTH/SB_DEPTH of sb_pkg (storage uses sb_entry_t).
module store_buffer
    import sb_pkg::*;
#(
    parameter int WIDTH = SB_WIDTH,
    parameter int DEPTH = SB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memwriteM,
    input  logic              loadM,
    input  logic [WIDTH-1:0]  aluresultM,
    input  logic [WIDTH-1:0]  writedataM,
    output logic [WIDTH-1:0]  readdataM,
    output logic              stallM,
    output logic [WIDTH-1:0]  ram_raddr,
    input  logic [WIDTH-1:0]  ram_rdata,
    store_buffer_if.master    ramWr,
    output logic              empty
);

    sb_entry_t             entries [DEPTH];
    logic [SB_PTR_W-1:0]   head;
    logic [SB_PTR_W-1:0]   tail;
    logic [SB_PTR_W:0]     count;

    logic                  full;
    logic                  isEmpty;
    logic                  enq;
    logic                  deq;
    logic                  hazardStall;
    logic [DEPTH-1:0]      validMask;
    logic [DEPTH-1:0]      matchVec;
    logic                  hit;
    logic [SB_PTR_W-1:0]   hitIdx;
    logic                  unusedBits;

    assign full    = (count == (SB_PTR_W+1)'(DEPTH));
    assign isEmpty = (count == '0);
    assign empty   = isEmpty;

    // A slot is valid when its distance from head is below count.
    always_comb begin
        validMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            validMask[i] = {1'b0, SB_PTR_W'(i) - head} < count;
        end
    end

    sb_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .entries    (entries),
        .validMask  (validMask),
        .head       (head),
        .count      (count),
        .lookupAddr (aluresultM),
        .matchVec   (matchVec),
        .hit        (hit),
        .hitIdx     (hitIdx)
    );

`ifdef STORE_FWD_EN
    assign hazardStall = 1'b0;
    assign readdataM   = (loadM && hit) ? entries[hitIdx].data : ram_rdata;
    assign unusedBits  = ^matchVec;
`else
    assign hazardStall = loadM && hit;
    assign readdataM   = ram_rdata;
    assign unusedBits  = ^{matchVec, hitIdx};
`endif

    // The full term ignores ram_wready so there is no ready-to-stall path.
    assign stallM    = (memwriteM && full) || hazardStall;
    assign enq       = memwriteM && !stallM;
    assign deq       = ramWr.ram_wvalid && ramWr.ram_wready;
    assign ram_raddr = aluresultM;

    assign ramWr.ram_wvalid = !isEmpty;
    assign ramWr.ram_waddr  = entries[head].addr;
    assign ramWr.ram_wdata  = entries[head].data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + SB_PTR_W'(1);
            end
            if (deq) begin
                head <= head + SB_PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + (SB_PTR_W+1)'(1);
                2'b01:   count <= count - (SB_PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage holds no control meaning, so it is not reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail] <= '{addr: aluresultM, data: writedataM};
        end
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the pipelined core's memory stage and the data RAM. Stores leaving the M stage are queued in a small FIFO and drained to the RAM write port over a valid/ready handshake, so a slow RAM write does not stall the core. Loads read the RAM combinationally. With forwarding compiled in, the youngest buffered store to the same word overrides the RAM data.

## Interface
- WIDTH, 32, data and address width.
- DEPTH, 4, number of buffer entries; must be a power of 2 and at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- memwriteM  in  1  store in the M stage; full-word stores only.
- loadM  in  1  load in the M stage.
- aluresultM  in  WIDTH  byte address for the M-stage access.
- writedataM  in  WIDTH  store data.
- readdataM  out  WIDTH  load data returned to the core (combinational).
- stallM  out  1  hold the M stage and all earlier stages; combinational.
- ram_raddr  out  WIDTH  RAM read address, equal to aluresultM.
- ram_rdata  in  WIDTH  RAM read data; combinational read.
- ram_wvalid  out  1  write request for the head entry.
- ram_wready  in  1  RAM accepts the write.
- ram_waddr  out  WIDTH  head entry address.
- ram_wdata  out  WIDTH  head entry data.
- empty  out  1  no valid entries; used for fence/drain.

## Operation
- State:
  - entries[DEPTH] of {addr, data};
  - head and tail pointers, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - count, log2(DEPTH)+1 bits.
  - full = (count == DEPTH); empty = (count == 0).
- Enqueue: memwriteM && !stallM writes {aluresultM, writedataM} to entries[tail], then tail increments.
- Dequeue: ram_wvalid && ram_wready, then head increments.
- ram_wvalid = !empty. ram_waddr and ram_wdata come from entries[head].
  - While ram_wvalid && !ram_wready, these are stable.
- Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
- stallM = (memwriteM && full) || hazard_stall.
  - The full term deliberately ignores ram_wready, so there is no combinational ready-to-stall path.
  - A stalled store is not enqueued. It is retried each cycle until accepted.
- Word match: entry i matches when it is valid and entries[i].addr[WIDTH-1:2] == aluresultM[WIDTH-1:2].
  - The match check includes the head entry even in a cycle where it is being accepted by the RAM.
- Loads: readdataM = ram_rdata unless forwarding applies (see Configuration).
- memwriteM && loadM together: the store is processed as normal; readdataM is don't-care.
- Address bits [1:0] are stored unchanged and not interpreted.

## Timing
- Reset (asynchronous assert, synchronous-edge release): head = tail = count = 0.
  - ram_wvalid = 0, empty = 1, stallM = 0, readdataM = ram_rdata.
- Reset mid-drain: all entries are discarded and ram_wvalid drops immediately. Data not yet written is lost; this is by design.
- Store-to-RAM latency: a store enqueued at edge N can complete on the RAM at edge N+1 at the earliest.
- Load latency: combinational, 0 cycles.
- Throughput: one enqueue and one dequeue per cycle.
- FIFO order is preserved; the RAM sees writes in program order.
- Pointer wrap: tail going from DEPTH-1 to 0 is a normal transition.
  - When full, head == tail; empty versus full is decided by count alone.

## Configuration
- STORE_FWD_EN defined:
  - hazard_stall = 0.
  - A load with any match returns the data of the youngest matching entry, meaning the one closest to tail-1, searching backwards.
  - No match: readdataM = ram_rdata.
- STORE_FWD_EN undefined:
  - No forwarding mux; readdataM = ram_rdata always.
  - hazard_stall = loadM && any match. The load stalls until every matching entry has drained.

## Structure
- Package sb_pkg holds:
  - typedef sb_entry_t {addr, data} sized by WIDTH;
  - localparam SB_PTR_W = $clog2(DEPTH);
  - function word_addr(), which drops the low 2 bits.
- One sub-module, sb_match: combinational match vector plus youngest-match priority select (index and hit), given entries, valid mask, head, count and the lookup address.
  - Used for forwarding and for hazard_stall.
- store_buffer owns the pointers, count, storage and handshake.

## Test plan
- Reset with ram_wready = 0, one store to 0x100 = 0xDEADBEEF:
  - ram_wvalid = 1 next cycle with addr 0x100 and data 0xDEADBEEF held stable 5 cycles;
  - raise ready: one write, then empty = 1.
- Fill:
  - 4 stores to 0x0, 0x4, 0x8, 0xC with ready = 0; a 5th store to 0x10 gives stallM = 1 and count stays 4;
  - ready = 1 for one cycle gives a 0x0 write; the 5th store enqueues the next cycle.
  - RAM order is 0x0, 0x4, 0x8, 0xC, 0x10 across the tail wrap.
- Forwarding (STORE_FWD_EN defined):
  - stores 0x20 = 0x11 then 0x20 = 0x22, ready = 0, load 0x20 with ram_rdata = 0x99 gives readdataM = 0x22;
  - load 0x22 (same word) also gives 0x22; load 0x24 gives 0x99.
- No forwarding (STORE_FWD_EN undefined):
  - same stores, load 0x20 gives stallM = 1 until the second 0x20 write handshakes;
  - then readdataM = ram_rdata.
- Simultaneous enqueue and dequeue with count = 2 and ready = 1 for 10 cycles, a store every cycle: count stays 2 and no stallM.
- Assert rst low with 3 entries pending and ready = 0: ram_wvalid = 0 and empty = 1 immediately, no RAM write after release.
